// File: rtl/move_sequencer.sv
// Queues 4-bit move codes and replays them through an external one-cycle cube datapath, one move every 2 cycles.
// mv_ready drops when the queue is full (further writes are dropped); define SOLVED_CHECK_EN to add the registered solved output.
module move_sequencer #(
  parameter int           FIFO_DEPTH   = 8,
  parameter logic [119:0] SOLVED_STATE = 120'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_valid,
  input  logic [119:0] init_state,
  input  logic         mv_valid,
  output logic         mv_ready,
  input  logic [3:0]   mv_code,
  input  logic         run,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [119:0] state_out,
  output logic [15:0]  move_count,
  output logic         dp_load,
  output logic [3:0]   dp_step,
  output logic [119:0] dp_d,
  input  logic [119:0] dp_q
`ifdef SOLVED_CHECK_EN
  ,
  output logic         solved
`endif
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_e;

  state_e        st_q, st_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [119:0]  cube_q, cube_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          wr, pop;
  logic [3:0]    head;

  always_comb begin
    wr       = mv_valid && (cnt_q != FULL_CNT);
    pop      = 1'b0;
    head     = mem_q[rd_ptr_q];
    st_d     = st_q;
    cube_d   = cube_q;
    count_d  = count_q;
    err_d    = err_q;
    dp_load  = 1'b0;
    dp_step  = 4'd0;
    done     = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (init_valid) begin
          cube_d  = init_state;
          count_d = 16'd0;
          err_d   = 1'b0;
        end else if (run) begin
          st_d = (cnt_q == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        dp_load = 1'b1;
        pop     = 1'b1;
        // Illegal codes are issued as "stay" so the cube is left untouched.
        if (head <= 4'd12) dp_step = head;
        else               err_d   = 1'b1;
        st_d = CAPTURE;
      end
      CAPTURE: begin
        cube_d = dp_q;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        // A write landing this cycle keeps the run going.
        st_d = ((cnt_q != '0) || wr) ? ISSUE : DONE;
      end
      DONE: begin
        done = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cube_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cube_q   <= cube_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= mv_code;
  end

  assign mv_ready   = (cnt_q != FULL_CNT);
  assign busy       = (st_q != IDLE);
  assign err        = err_q;
  assign state_out  = cube_q;
  assign dp_d       = cube_q;
  assign move_count = count_q;

`ifdef SOLVED_CHECK_EN
  logic solved_q, solved_d;

  always_comb begin
    solved_d = (cube_q == SOLVED_STATE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) solved_q <= 1'b0;
    else     solved_q <= solved_d;
  end

  assign solved = solved_q;
`endif

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: move-queue depth in entries; power of two, at least 2.
REQ-002 Parameter SOLVED_STATE, 120 bits, default 120'd0: packed cube vector treated as solved.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 init_valid  input  1  load init_state as the working cube state.
REQ-006 init_state  input  120  packed cube state to load.
REQ-007 mv_valid  input  1  move-queue write request.
REQ-008 mv_ready  output  1  queue not full; a write occurs when mv_valid && mv_ready.
REQ-009 mv_code  input  4  move code: 0 stay, 1..12 face turns, 13..15 illegal.
REQ-010 run  input  1  start executing the queued moves.
REQ-011 busy  output  1  sequencer not IDLE.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 err  output  1  sticky flag: an illegal code was executed.
REQ-014 state_out  output  120  current working cube state.
REQ-015 move_count  output  16  moves executed since the last init load.
REQ-016 dp_load  output  1  datapath load strobe.
REQ-017 dp_step  output  4  datapath move code.
REQ-018 dp_d  output  120  datapath input state; always equals the working state.
REQ-019 dp_q  input  120  datapath result, valid one cycle after dp_load.

Function
REQ-020 The queue SHALL be a FIFO of FIFO_DEPTH 4-bit entries; mv_ready = !full.
REQ-021 The FSM SHALL have states IDLE, ISSUE, CAPTURE and DONE.
REQ-022 IDLE: init_valid SHALL load init_state and clear move_count and err; it is ignored in all other states; init_valid takes priority over run in the same cycle.
REQ-023 IDLE: run with a non-empty queue SHALL go to ISSUE; run with an empty queue SHALL go to DONE.
REQ-024 ISSUE: dp_load=1, dp_step=head code, queue pop; then go to CAPTURE.
REQ-025 ISSUE with an illegal code: dp_step=0 and err set; the move still counts.
REQ-026 CAPTURE: dp_load=0; working state <= dp_q; move_count +1, saturating at 16'hFFFF; go to ISSUE if the queue is non-empty after this cycle's write, else DONE.
REQ-027 DONE: done=1 for exactly one cycle; then go to IDLE.
REQ-028 Outside ISSUE, dp_load SHALL be 0 and dp_step SHALL be 0.
REQ-029 Throughput SHALL be one move per 2 cycles; run sampled at edge 0 gives ISSUE in cycle 1, CAPTURE in cycle 2 and done in cycle 3 for a single move.
REQ-030 Writes are accepted in every state; a write and a pop in the same cycle SHALL both take effect; a write while full is dropped.
REQ-031 run SHALL be ignored while busy.

Reset
REQ-032 While rst is high, these SHALL be 0: FSM state (IDLE), queue (flushed), working state, move_count, err, done, dp_load and dp_step; mv_ready SHALL be 1.
REQ-033 Reset asserted mid-run SHALL abort immediately; no done pulse is produced.

Configuration
REQ-034 With SOLVED_CHECK_EN defined, the block SHALL add output solved (1 bit), registered, high when the working state == SOLVED_STATE, and 0 in reset.
REQ-035 Without SOLVED_CHECK_EN, the solved port and the comparator SHALL be absent.

Verification
REQ-036 Reset: pulse rst asynchronously mid-cycle -> all outputs 0 immediately except mv_ready=1.
REQ-037 Load state A, push code 1, pulse run at edge 0 -> dp_load=1 and dp_step=1 with dp_d=A in cycle 1; state_out=dp_q and done=1 in cycle 3; move_count=1.
REQ-038 With change_cube in loop: push code 1 four times, then run -> state_out=A, move_count=4, busy for 9 cycles.
REQ-039 Push 9 codes with no run -> mv_ready=0 after the 8th write and the 9th is dropped; run executes exactly 8 moves.
REQ-040 Push code 14, then run -> dp_step=0, err=1, state_out unchanged, move_count=1.
REQ-041 Assert rst during CAPTURE of a 3-move run -> busy=0, queue empty, move_count=0, no done pulse; with SOLVED_CHECK_EN, loading SOLVED_STATE gives solved=1 the next cycle.
